// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch controller: IDLE/REQ/DONE/ERR handshake with memory, PC tracking and timeout.
// Optional define FETCH_MISALIGN_CHECK_EN rejects unaligned redirects and adds the misalign pulse output.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  input  logic        pc_load,
  input  logic [31:0] pc_target,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] PC,
  output logic [31:0] RD,
  output logic        IRWrite,
  output logic        busy,
  output logic        fetch_err
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        misalign
`endif
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_next_q, pc_next_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   rd_q, rd_d;
  logic [XLEN-1:0]   pend_addr_q, pend_addr_d;
  logic              pend_q, pend_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]  wait_inc;
  logic              mem_req_q, mem_req_d;
  logic              irwrite_q, irwrite_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              mis_q, mis_d;
  logic              load_ok;
  logic [XLEN-1:0]   load_tgt;

  assign wait_inc = wait_q + CNT_W'(1);

  // Qualify redirect requests: reject or force-align the low address bits
  always_comb begin
    mis_d = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    load_ok  = pc_load && (pc_target[1:0] == 2'b00);
    load_tgt = pc_target;
    mis_d    = pc_load && (pc_target[1:0] != 2'b00);
`else
    load_ok  = pc_load;
    load_tgt = {pc_target[XLEN-1:2], 2'b00};
`endif
  end

`ifndef FETCH_MISALIGN_CHECK_EN
  logic unused_tgt_lsb;
  assign unused_tgt_lsb = ^{pc_target[1:0], mis_q};
`endif

  always_comb begin
    state_d     = state_q;
    pc_next_d   = pc_next_q;
    mem_addr_d  = mem_addr_q;
    pc_d        = pc_q;
    rd_d        = rd_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    wait_d      = wait_q;
    mem_req_d   = 1'b0;
    irwrite_d   = 1'b0;
    busy_d      = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (load_ok) pc_next_d = load_tgt;
        if (fetch_en) begin
          state_d    = REQ;
          mem_addr_d = load_ok ? load_tgt : pc_next_q;
          wait_d     = '0;
        end
      end
      REQ: begin
        if (load_ok) begin
          pend_d      = 1'b1;
          pend_addr_d = load_tgt;
        end
        if (mem_ready) begin
          rd_d      = mem_rdata;
          pc_d      = mem_addr_q;
          pc_next_d = mem_addr_q + XLEN'(4);
          state_d   = DONE;
        end else begin
          wait_d = wait_inc;
          if (wait_inc >= TIMEOUT) state_d = ERR;
        end
      end
      DONE: begin
        // A redirect seen during the fetch overrides the sequential +4 on return to IDLE
        state_d = IDLE;
        pend_d  = 1'b0;
        if (load_ok)     pc_next_d = load_tgt;
        else if (pend_q) pc_next_d = pend_addr_q;
      end
      default: ;
    endcase

    mem_req_d = (state_d == REQ);
    irwrite_d = (state_d == DONE);
    busy_d    = (state_d != IDLE);
    err_d     = (state_d == ERR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_next_q   <= RESET_PC;
      mem_addr_q  <= RESET_PC;
      pc_q        <= RESET_PC;
      rd_q        <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      wait_q      <= '0;
      mem_req_q   <= 1'b0;
      irwrite_q   <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_next_q   <= pc_next_d;
      mem_addr_q  <= mem_addr_d;
      pc_q        <= pc_d;
      rd_q        <= rd_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      wait_q      <= wait_d;
      mem_req_q   <= mem_req_d;
      irwrite_q   <= irwrite_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      mis_q       <= mis_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign PC        = pc_q;
  assign RD        = rd_q;
  assign IRWrite   = irwrite_q;
  assign busy      = busy_q;
  assign fetch_err = err_q;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign  = mis_q;
`endif

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Parameter TIMEOUT, default 8'd255, SHALL be the maximum number of REQ cycles to wait for mem_ready before error.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 fetch_en  input  1  SHALL request fetch of the instruction at pc_next.
REQ-006 pc_load  input  1  SHALL redirect the fetch stream to pc_target (branch/jump).
REQ-007 pc_target  input  32  SHALL be the redirect address.
REQ-008 mem_rdata  input  32  SHALL be the instruction word from memory, valid when mem_ready=1.
REQ-009 mem_ready  input  1  SHALL be the memory read acknowledge.
REQ-010 mem_req  output  1  SHALL be the memory read request.
REQ-011 mem_addr  output  32  SHALL be the memory read address.
REQ-012 PC  output  32  SHALL be the address of the instruction held in RD.
REQ-013 RD  output  32  SHALL be the captured instruction word for the downstream instruction register.
REQ-014 IRWrite  output  1  SHALL be a one-cycle pulse marking RD/PC as new.
REQ-015 busy  output  1  SHALL be 1 in any state other than IDLE.
REQ-016 fetch_err  output  1  SHALL be a sticky memory-timeout flag.

Function
REQ-017 FSM states SHALL be IDLE, REQ, DONE, ERR.
REQ-018 IDLE: fetch_en=1 SHALL move to REQ, latching fetch address = pc_next into mem_addr; otherwise stay.
REQ-019 REQ: mem_req SHALL be 1 and mem_addr held stable until mem_ready=1.
REQ-020 REQ with mem_ready=1 SHALL capture RD<=mem_rdata, PC<=mem_addr, pc_next<=mem_addr+4, and move to DONE; mem_req drops the next cycle.
REQ-021 DONE: IRWrite SHALL be 1 for exactly that cycle, then the FSM SHALL return to IDLE; fetch-to-IRWrite minimum latency is 3 cycles (IDLE->REQ->DONE).
REQ-022 pc_next+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-023 pc_load in IDLE SHALL set pc_next<=pc_target; with fetch_en in the same cycle, that fetch SHALL use pc_target.
REQ-024 pc_load in REQ or DONE SHALL be held pending and applied when the FSM next enters IDLE, overriding the +4 update; the latest pending pc_load SHALL win.
REQ-025 A wait counter SHALL clear on REQ entry and increment every REQ cycle without mem_ready; reaching TIMEOUT SHALL move to ERR.
REQ-026 ERR: fetch_err=1, mem_req=0, IRWrite=0; the FSM SHALL leave ERR only through reset.
REQ-027 mem_ready outside REQ SHALL be ignored.

Reset
REQ-028 Reset SHALL immediately force IDLE, pc_next=RESET_PC, PC=RESET_PC, RD=0, mem_addr=RESET_PC, mem_req=0, IRWrite=0, busy=0, fetch_err=0, wait counter=0, and no pending load.
REQ-029 Reset asserted mid-REQ SHALL abort the transaction; a later mem_ready SHALL NOT update RD.

Configuration
REQ-030 With macro FETCH_MISALIGN_CHECK_EN defined, pc_load with pc_target[1:0]!=0 SHALL be ignored and output misalign (1 bit) SHALL pulse for one cycle.
REQ-031 Without FETCH_MISALIGN_CHECK_EN, the misalign port SHALL be absent and pc_target[1:0] SHALL be forced to 2'b00 on load.

Verification
REQ-032 Reset, fetch_en=1, mem_ready after 1 wait cycle with mem_rdata=32'h00500093 -> mem_addr=0, RD=32'h00500093, PC=0, one IRWrite pulse, next fetch at 32'h4.
REQ-033 pc_load=1 with pc_target=32'h100 and fetch_en=1 in IDLE -> mem_addr=32'h100.
REQ-034 pc_load with target 32'h200 during REQ -> current fetch completes, next fetch at 32'h200 rather than +4.
REQ-035 Hold mem_ready=0 -> fetch_err=1 after 255 REQ cycles, mem_req=0, FSM stuck until reset.
REQ-036 With pc_next=32'hFFFF_FFFC, complete a fetch -> next mem_addr=32'h0000_0000.
REQ-037 With FETCH_MISALIGN_CHECK_EN, pc_target=32'h102 -> misalign pulse, pc_next unchanged; without it, next fetch at 32'h100.
